xy_truth_table_prober: RTL and testbench

Sequential stimulus-and-check engine for 2-input/1-output combinational blocks such as the existing x/y -> z functions.
- Drives every {x,y} combination onto a device under test.
- Waits a programmable settle time, samples z and compares it with a 4-bit expected truth table latched at start.
- Reports pass/fail, a per-vector mismatch mask and a saturating mismatch count.
- Sits beside the combinational blocks in self-check harnesses and on-chip BIST wrappers.

---
 rtl/xy_probe_pkg.sv | 12 +
 rtl/xy_truth_table_prober_if.sv | 30 +++
 rtl/xy_truth_table_prober_settle_timer.sv | 27 ++
 rtl/xy_truth_table_prober.sv | 122 ++++++++++++
 tb/tb_xy_truth_table_prober.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/xy_probe_pkg.sv
// Shared types and constants for the x/y truth-table prober.
// Vector index is {x,y}; four vectors cover the full 2-input space.
package xy_probe_pkg;
  localparam int VEC_W   = 2;
  localparam int NUM_VEC = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;
endpackage

// File: rtl/xy_truth_table_prober_if.sv
// Stimulus/response bundle between a harness and the prober.
// The harness is master; the prober is slave.
interface xy_truth_table_prober_if
  import xy_probe_pkg::*;
#(
  parameter int CNT_W = 4
);
  logic               start;
  logic [NUM_VEC-1:0] expected_tt;
  logic               z_in;
  logic               x_out;
  logic               y_out;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_VEC-1:0] mismatch_mask;
  logic [CNT_W-1:0]   mismatch_count;

  modport master (
    output start, expected_tt, z_in,
    input  x_out, y_out, busy, done,
    input  pass, mismatch_mask, mismatch_count
  );

  modport slave (
    input  start, expected_tt, z_in,
    output x_out, y_out, busy, done,
    output pass, mismatch_mask, mismatch_count
  );
endinterface

// File: rtl/xy_truth_table_prober_settle_timer.sv
// Loadable down-counter marking the sample edge of each held vector.
// Sits at zero once expired until reloaded.
module xy_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic load,
  input  logic tick,
  output logic is_zero
);
  localparam int TW = $clog2(SETTLE_CYCLES + 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= TW'(SETTLE_CYCLES - 1);
    end else if (tick && cnt_q != '0) begin
      cnt_q <= cnt_q - TW'(1);
    end
  end

  assign is_zero = (cnt_q == '0);
endmodule

// File: rtl/xy_truth_table_prober.sv
// Sweeps every {x,y}, samples z after a settle time and accumulates
// mismatches against the truth table latched at start.
module xy_truth_table_prober
  import xy_probe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int REPEAT        = 1,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic resetn,
  xy_truth_table_prober_if.slave bus
);
  localparam int SW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  state_e state_q, state_d;

  logic [VEC_W-1:0]   idx_q;
  logic [VEC_W-1:0]   xy_q;
  logic [SW-1:0]      sweep_q;
  logic [NUM_VEC-1:0] tt_q;
  logic [NUM_VEC-1:0] mask_q;
  logic [NUM_VEC-1:0] hit;
  logic [CNT_W-1:0]   cnt_q;
  logic               pass_q;

  logic accept, smp, miss;
  logic last_vec, last_sweep, finish;
  logic t_load, t_tick, t_zero;
  logic busy, done;

  xy_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk     (clk),
    .resetn  (resetn),
    .load    (t_load),
    .tick    (t_tick),
    .is_zero (t_zero)
  );

  assign accept     = (state_q == IDLE) && bus.start;
  assign smp        = (state_q == RUN) && t_zero;
  assign miss       = bus.z_in != tt_q[idx_q];
  assign hit        = miss ? (NUM_VEC'(1) << idx_q) : '0;
  assign last_vec   = idx_q == VEC_W'(NUM_VEC - 1);
  assign last_sweep = sweep_q == SW'(REPEAT - 1);
  assign finish     = smp && last_vec && last_sweep;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (accept) state_d = RUN;
      state_q == RUN:  if (finish) state_d = DONE;
      state_q == DONE: state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    t_load = 1'b0;
    t_tick = 1'b0;
    unique case (1'b1)
      state_q == IDLE: t_load = bus.start;
      state_q == RUN: begin
        busy   = 1'b1;
        t_load = t_zero;
        t_tick = !t_zero;
      end
      state_q == DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Final pass verdict must include the compare made on the last edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tt_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      idx_q   <= '0;
      sweep_q <= '0;
      xy_q    <= '0;
    end else if (accept) begin
      tt_q    <= bus.expected_tt;
      mask_q  <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      idx_q   <= '0;
      sweep_q <= '0;
      xy_q    <= '0;
    end else if (smp) begin
      mask_q <= mask_q | hit;
      if (miss && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      if (!last_vec) begin
        idx_q <= idx_q + VEC_W'(1);
        xy_q  <= idx_q + VEC_W'(1);
      end else begin
        idx_q <= '0;
        xy_q  <= '0;
        if (!last_sweep) sweep_q <= sweep_q + SW'(1);
        else             pass_q  <= (mask_q | hit) == '0;
      end
    end
  end

  assign bus.x_out          = xy_q[1];
  assign bus.y_out          = xy_q[0];
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass_q;
  assign bus.mismatch_mask  = mask_q;
  assign bus.mismatch_count = cnt_q;
endmodule

// File: tb/tb_xy_truth_table_prober.sv
// Bench for xy_truth_table_prober: three configurations checked
// against a cycle-count model plus literal result pins.
module tb_xy_truth_table_prober;
  localparam int N = 3;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic       start_r [N];
  logic [3:0] tt_r    [N];
  int         zmode   [N];

  logic       xo [N];
  logic       yo [N];
  logic       bo [N];
  logic       dno[N];
  logic       po [N];
  logic       zi [N];
  logic [3:0] mo [N];
  logic [3:0] co [N];

  int n_cmp = 0;
  int n_bad = 0;

  logic       m_act [N];
  int         m_k   [N];
  logic [3:0] m_tt  [N];
  logic [3:0] m_mask[N];
  int         m_cnt [N];
  logic       m_done[N];
  logic       m_pass[N];

  function automatic int s_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int r_of(input int i);
    return (i == 2) ? 6 : 1;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int S = (g == 1) ? 3 : 1;
    localparam int R = (g == 2) ? 6 : 1;

    xy_truth_table_prober_if #(.CNT_W(4)) bus ();

    xy_truth_table_prober #(
      .SETTLE_CYCLES(S),
      .REPEAT       (R),
      .CNT_W        (4)
    ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
    );

    assign bus.start       = start_r[g];
    assign bus.expected_tt = tt_r[g];
    assign bus.z_in =
      (zmode[g] == 0) ? (bus.x_out & ~bus.y_out) :
      (zmode[g] == 1) ? ~m_tt[g][{bus.x_out, bus.y_out}] :
      (m_act[g] && (m_k[g] % S) < 2);

    assign zi[g]  = bus.z_in;
    assign xo[g]  = bus.x_out;
    assign yo[g]  = bus.y_out;
    assign bo[g]  = bus.busy;
    assign dno[g] = bus.done;
    assign po[g]  = bus.pass;
    assign mo[g]  = bus.mismatch_mask;
    assign co[g]  = bus.mismatch_count;
  end

  // Model: k counts edges since the accepted start; vector j is
  // sampled on edge (j+1)*S of each sweep.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) begin
        m_act[i]  <= 1'b0;
        m_k[i]    <= 0;
        m_tt[i]   <= '0;
        m_mask[i] <= '0;
        m_cnt[i]  <= 0;
        m_done[i] <= 1'b0;
        m_pass[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        automatic int         k  = m_k[i] + 1;
        automatic logic [3:0] mk = m_mask[i];
        automatic int         c  = m_cnt[i];
        automatic int         j  = 0;
        m_done[i] <= 1'b0;
        if (m_act[i]) begin
          m_k[i] <= k;
          if (k % s_of(i) == 0) begin
            j = (k / s_of(i) - 1) % 4;
            if (zi[i] !== m_tt[i][j]) begin
              mk[j] = 1'b1;
              c++;
            end
          end
          m_mask[i] <= mk;
          m_cnt[i]  <= c;
          if (k == 4 * r_of(i) * s_of(i)) begin
            m_act[i]  <= 1'b0;
            m_done[i] <= 1'b1;
            m_pass[i] <= (mk == 4'b0000);
          end
        end else if (!m_done[i] && start_r[i]) begin
          m_act[i]  <= 1'b1;
          m_k[i]    <= 0;
          m_tt[i]   <= tt_r[i];
          m_mask[i] <= '0;
          m_cnt[i]  <= 0;
          m_pass[i] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int i,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, i, act, exp);
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < N; i++) begin
      automatic int v = m_act[i] ? (m_k[i] / s_of(i)) % 4 : 0;
      automatic int c = (m_cnt[i] > 15) ? 15 : m_cnt[i];
      chk("x_out", i, 32'(xo[i]), 32'(v / 2));
      chk("y_out", i, 32'(yo[i]), 32'(v % 2));
      chk("busy",  i, 32'(bo[i]), 32'(m_act[i]));
      chk("done",  i, 32'(dno[i]), 32'(m_done[i]));
      chk("pass",  i, 32'(po[i]), 32'(m_pass[i]));
      chk("mask",  i, 32'(mo[i]), 32'(m_mask[i]));
      chk("count", i, 32'(co[i]), 32'(c));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic wait_done(input int i, input int lat);
    automatic int got = -1;
    for (int n = 1; n <= 200; n++) begin
      step();
      if (dno[i] === 1'b1) begin
        got = n;
        break;
      end
    end
    chk("latency", i, 32'(got), 32'(lat));
  endtask

  task automatic run(input int i, input logic [3:0] t,
                     input int md, input int lat);
    zmode[i]   = md;
    tt_r[i]    = t;
    start_r[i] = 1'b1;
    step();
    start_r[i] = 1'b0;
    wait_done(i, lat);
    step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      start_r[i] = 1'b0;
      tt_r[i]    = '0;
      zmode[i]   = 0;
    end
    resetn = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) step();
    chk("rst_busy", 0, 32'(bo[0]), 32'd0);
    chk("rst_mask", 0, 32'(mo[0]), 32'd0);
    #2 resetn = 1'b1;

    // Reset asserted in the middle of a run
    tt_r[0]    = 4'b0100;
    start_r[0] = 1'b1;
    step();
    start_r[0] = 1'b0;
    step();
    chk("midrun_busy", 0, 32'(bo[0]), 32'd1);
    #2 resetn = 1'b0;
    #1;
    cmp_all();
    chk("arst_busy", 0, 32'(bo[0]), 32'd0);
    chk("arst_x",    0, 32'(xo[0]), 32'd0);
    step();
    #2 resetn = 1'b1;
    repeat (3) step();
    chk("idle_after_rst", 0, 32'(bo[0]), 32'd0);

    // Clean pass with AND-NOT loopback
    run(0, 4'b0100, 0, 4);
    chk("clean_pass",  0, 32'(po[0]), 32'd1);
    chk("clean_mask",  0, 32'(mo[0]), 32'd0);
    chk("clean_count", 0, 32'(co[0]), 32'd0);

    // XNOR table against AND-NOT loopback
    run(0, 4'b1001, 0, 4);
    chk("xnor_pass",  0, 32'(po[0]), 32'd0);
    chk("xnor_mask",  0, 32'(mo[0]), 32'hd);
    chk("xnor_count", 0, 32'(co[0]), 32'd3);

    // Six sweeps, every sample wrong: count saturates
    run(2, 4'b0110, 1, 24);
    chk("sat_count", 2, 32'(co[2]), 32'd15);
    chk("sat_mask",  2, 32'(mo[2]), 32'hf);
    chk("sat_pass",  2, 32'(po[2]), 32'd0);

    // Settle of 3: z is only correct in the last cycle
    run(1, 4'b0000, 2, 12);
    chk("settle_pass", 1, 32'(po[1]), 32'd1);
    chk("settle_mask", 1, 32'(mo[1]), 32'd0);

    // start and expected_tt disturbed mid-run
    zmode[0]   = 0;
    tt_r[0]    = 4'b0100;
    start_r[0] = 1'b1;
    step();
    start_r[0] = 1'b0;
    step();
    start_r[0] = 1'b1;
    tt_r[0]    = 4'b1001;
    step();
    start_r[0] = 1'b0;
    wait_done(0, 2);
    chk("ign_pass", 0, 32'(po[0]), 32'd1);
    chk("ign_mask", 0, 32'(mo[0]), 32'd0);

    // start held from the DONE cycle into the following IDLE cycle
    start_r[0] = 1'b1;
    step();
    chk("done_start_ign", 0, 32'(bo[0]), 32'd0);
    step();
    start_r[0] = 1'b0;
    chk("restart_busy", 0, 32'(bo[0]), 32'd1);
    chk("restart_pass", 0, 32'(po[0]), 32'd0);
    wait_done(0, 4);
    chk("restart_mask", 0, 32'(mo[0]), 32'hd);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
